// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// Bit time is PSCALER sysclk cycles; the serial line is registered and idles high.
module uart_tx #(
  parameter int N         = 10,
  parameter int PSCALER   = 625,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_o,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic [N-1:0] PS_LAST   = N'(PSCALER - 1);
  localparam logic         STOP_LAST = 1'(STOP_BITS - 1);

  state_t       state, state_n;
  logic [N-1:0] psc, psc_n;
  logic [2:0]   bit_cnt, bit_cnt_n;
  logic         stop_cnt, stop_cnt_n;
  logic [7:0]   sreg, sreg_n;
  logic         par_bit, par_bit_n;
  logic         tx_q, tx_n;
  logic         done_q, done_n;
  logic         tick;

  assign tick = (psc == PS_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= IDLE;
      psc      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      sreg     <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      psc      <= psc_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      sreg     <= sreg_n;
      par_bit  <= par_bit_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
    end
  end

  // The line level for the next cycle is chosen alongside the state transition,
  // so tx_o is a plain flop that changes exactly on bit boundaries.
  always_comb begin
    state_n    = state;
    psc_n      = tick ? '0 : psc + 1'b1;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    sreg_n     = sreg;
    par_bit_n  = par_bit;
    tx_n       = tx_q;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        psc_n = '0;
        tx_n  = 1'b1;
        if (tx_valid) begin
          sreg_n    = tx_data;
          par_bit_n = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
          bit_cnt_n = '0;
          state_n   = START;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          tx_n    = sreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt_n  = '0;
            stop_cnt_n = 1'b0;
            if (PARITY != 0) begin
              state_n = PAR;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            sreg_n    = {1'b0, sreg[7:1]};
            tx_n      = sreg[1];
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_n    = STOP;
          stop_cnt_n = 1'b0;
          tx_n       = 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            state_n    = IDLE;
            stop_cnt_n = 1'b0;
            done_n     = 1'b1;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end
      default: begin
        state_n    = IDLE;
        psc_n      = '0;
        bit_cnt_n  = '0;
        stop_cnt_n = 1'b0;
        tx_n       = 1'b1;
      end
    endcase
  end

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign tx_o     = tx_q;
  assign tx_done  = done_q;

endmodule
